// File: rtl/imem_arbiter_pkg.sv
// imem_arb_pkg: shared types and master ids for the instruction-memory arbiter
package imem_arb_pkg;
  typedef enum logic {ARB_RR, ARB_LOCK} arb_state_e;
  localparam logic MID_M0 = 1'b0;
  localparam logic MID_M1 = 1'b1;
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin pick, the master that did not win last time takes a tie
import imem_arb_pkg::*;
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);
  // a lone requester always wins; on a tie the master other than last_gnt wins
  always_comb begin
    gnt[0] = req[0] & (!req[1] | (last_gnt == MID_M1));
    gnt[1] = req[1] & (!req[0] | (last_gnt == MID_M0));
  end
endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the instruction memory between core fetch (M0) and a lockable loader (M1)
import imem_arb_pkg::*;
module imem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = $clog2(LOCK_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
  arb_state_e       state, state_d;
  logic [CNT_W-1:0] lock_cnt, cnt_d;
  logic             last_gnt, last_d;
  logic [1:0]       pick;
  rd_tag_t          rd_tag;
  arb_rr2 u_rr (
    .req      ({m1_req, m0_req}),
    .last_gnt (last_gnt),
    .gnt      (pick)
  );
  // grants and memory mux; grants are forced low while reset is asserted
  always_comb begin
    m0_gnt    = rst_n && (state == ARB_RR) && pick[0];
    m1_gnt    = rst_n && ((state == ARB_LOCK) ? m1_req : pick[1]);
    mem_en    = m0_gnt | m1_gnt;
    mem_we    = m1_gnt & m1_we;
    mem_addr  = m0_gnt ? m0_addr : (m1_gnt ? m1_addr : '0);
    mem_wdata = m1_gnt ? m1_wdata : '0;
    m0_rvalid = rd_tag.valid && (rd_tag.id == MID_M0);
    m1_rvalid = rd_tag.valid && (rd_tag.id == MID_M1);
    m0_rdata  = mem_rdata;
    m1_rdata  = mem_rdata;
  end
  // lock FSM: enter on a locked M1 issue, leave on release or when the lock budget is spent
  always_comb begin
    state_d = state;
    cnt_d   = lock_cnt;
    last_d  = m0_gnt ? MID_M0 : (m1_gnt ? MID_M1 : last_gnt);
    if (state == ARB_RR) begin
      if (m1_gnt && m1_lock) begin
        state_d = ARB_LOCK;
        cnt_d   = '0;
      end
    end else if (!m1_lock || (lock_cnt == CNT_LAST)) begin
      state_d = ARB_RR;
      cnt_d   = '0;
      if (lock_cnt == CNT_LAST) last_d = MID_M1;
    end else begin
      cnt_d = lock_cnt + CNT_W'(1);
    end
  end
  // arbitration state, lock counter and read-return tag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_RR;
      lock_cnt <= '0;
      last_gnt <= MID_M1;
      rd_tag   <= '0;
    end else begin
      state    <= state_d;
      lock_cnt <= cnt_d;
      last_gnt <= last_d;
      rd_tag   <= '{valid: mem_en & ~mem_we, id: m1_gnt};
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized and directed checks of imem_arbiter against a behavioural model
module tb_imem_arbiter;
  localparam int LM = 4;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        m0_req = 1'b0, m1_req = 1'b0, m1_we = 1'b0, m1_lock = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m1_wdata = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_en, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [16];
  logic [31:0] shadow [16];
  logic [31:0] seed;
  int          errors = 0, checks = 0;
  bit          m_last, m_locked, exp_rv0, exp_rv1;
  int          m_used;
  logic [31:0] exp_rdata;

  imem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(LM)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return seed ^ (32'(i) * 32'h9E3779B9);
  endfunction

  // synchronous single-port memory, reloaded with known contents during reset
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_last   = 1'b1;
    m_locked = 1'b0;
    m_used   = 0;
    exp_rv0  = 1'b0;
    exp_rv1  = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
  endtask

  // one bus cycle: drive, compare against the model's prediction, advance the model
  task automatic step(input bit r0, input logic [31:0] a0, input bit r1, input bit we1,
                      input logic [31:0] a1, input logic [31:0] wd1, input bit lk1);
    bit g0, g1;
    m0_req = r0; m0_addr = a0; m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = wd1; m1_lock = lk1;
    #1;
    if (m_locked) begin
      g0 = 1'b0; g1 = r1;
    end else if (r0 && r1) begin
      g0 = m_last; g1 = !m_last;
    end else begin
      g0 = r0; g1 = r1;
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(g0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g1));
    chk("mem_en", 32'(mem_en), 32'(g0 | g1));
    chk("mem_we", 32'(mem_we), 32'(g1 & we1));
    chk("mem_addr", mem_addr, g0 ? a0 : (g1 ? a1 : 32'h0));
    chk("mem_wdata", mem_wdata, g1 ? wd1 : 32'h0);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
    if (exp_rv0) chk("m0_rdata", m0_rdata, exp_rdata);
    if (exp_rv1) chk("m1_rdata", m1_rdata, exp_rdata);
    exp_rv0 = g0;
    exp_rv1 = g1 && !we1;
    if (g0) exp_rdata = shadow[a0[5:2]];
    if (g1 && !we1) exp_rdata = shadow[a1[5:2]];
    if (g1 && we1) shadow[a1[5:2]] = wd1;
    if (g0) m_last = 1'b0;
    if (g1) m_last = 1'b1;
    if (m_locked) begin
      m_used++;
      if (m_used == LM) m_last = 1'b1;
      if (!lk1 || m_used == LM) begin
        m_locked = 1'b0;
        m_used = 0;
      end
    end else if (g1 && lk1) begin
      m_locked = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    bit lk;
    seed = $urandom;
    model_reset();
    m0_req = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // fetch stream with the loader idle
    step(1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    step(1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
    step(1, 32'h8, 0, 0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // both masters reading, grants alternate
    for (int i = 0; i < 6; i++) step(1, 32'(i * 4), 1, 0, 32'(32 + i * 4), 32'h0, 0);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // loader write followed by a fetch of the same word
    step(0, 32'h0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
    step(1, 32'h10, 0, 0, 32'h0, 32'h0, 0);
    chk("t3_rdata", m0_rdata, 32'hDEADBEEF);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // lock held continuously: forced release, fetch gets a slot, loader relocks
    for (int i = 0; i < 2 * LM + 4; i++) step(1, 32'h20, 1, 0, 32'(i * 4), 32'h0, 1);
    step(0, 32'h0, 0, 0, 32'h0, 32'h0, 0);
    // lock dropped after two locked cycles while the fetch port waits
    step(0, 32'h0, 1, 0, 32'h4, 32'h0, 1);
    step(1, 32'h8, 1, 0, 32'h4, 32'h0, 1);
    step(1, 32'h8, 1, 0, 32'h4, 32'h0, 1);
    step(1, 32'h8, 0, 0, 32'h4, 32'h0, 0);
    step(1, 32'hC, 0, 0, 32'h4, 32'h0, 0);
    // reset one cycle after a read issue drops the read immediately
    step(1, 32'h8, 0, 0, 32'h0, 32'h0, 0);
    m0_req = 1'b1; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h3C; m1_wdata = 32'h1234;
    rst_n = 1'b0;
    #1;
    chk("t6_m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("t6_m1_rvalid", 32'(m1_rvalid), 32'h0);
    chk("t6_m0_gnt", 32'(m0_gnt), 32'h0);
    chk("t6_m1_gnt", 32'(m1_gnt), 32'h0);
    chk("t6_mem_we", 32'(mem_we), 32'h0);
    chk("t6_mem_addr", mem_addr, 32'h0);
    chk("t6_mem_wdata", mem_wdata, 32'h0);
    model_reset();
    @(negedge clk);
    chk("t6_hold_rvalid", 32'(m0_rvalid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 32'h4, 1, 0, 32'h8, 32'h0, 0);
    step(1, 32'h4, 1, 0, 32'h8, 32'h0, 0);
    // randomized traffic with a slowly toggling lock request
    lk = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) lk = !lk;
      step(1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, lk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
